// File: rtl/wdog_pkg.sv
// Shared definitions for the watchdog family: sequencer state encoding and
// the nanosecond-to-clock-cycle conversion used to size every timer.
package wdog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_LOCKED  = 2'd3
  } seq_state_e;

  // Computed in 64 bits so long windows at fast clocks do not overflow, then truncated.
  function automatic logic [31:0] ns_to_cycles(input logic [63:0] ns, input logic [63:0] clk_hz);
    logic [63:0] prod;
    prod = (ns * clk_hz) / 64'd1000000000;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/wdog_win_timer.sv
// Free-running escalation window timer: counts 0..P_WIN_CYC, pulses o_wrap on
// the terminal count, and restarts from 0 on a synchronous clear.
module wdog_win_timer #(
  parameter logic [31:0] P_WIN_CYC = 32'd1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_wrap
);

  logic [31:0] r_cnt;
  logic        w_at_end;

  assign w_at_end = (r_cnt == P_WIN_CYC);
  // A clear takes priority, so no wrap is reported in the cycle it lands.
  assign o_wrap   = w_at_end & ~i_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/wdog_rst_seq.sv
// Watchdog reset sequencer: holds a bank of active-low resets after a kick,
// releases them in order, and locks up after too many kicks in one window.
module wdog_rst_seq
  import wdog_pkg::*;
#(
  parameter logic [63:0] P_CLK_FREQ_HZ   = 64'd100000000,
  parameter logic [63:0] P_HOLD_NS       = 64'd1000,
  parameter logic [63:0] P_STAGE_NS      = 64'd500,
  parameter int          P_N_STAGES      = 4,
  parameter int          P_ESC_KICKS     = 3,
  parameter logic [63:0] P_ESC_WINDOW_NS = 64'd2000000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kick,
  input  logic                  clr_esc,
  output logic [P_N_STAGES-1:0] rst_out_n,
  output logic                  busy,
  output logic                  escalated,
  output logic [15:0]           kick_cnt
);

  localparam logic [31:0] L_HOLD  = ns_to_cycles(P_HOLD_NS, P_CLK_FREQ_HZ);
  localparam logic [31:0] L_STAGE = ns_to_cycles(P_STAGE_NS, P_CLK_FREQ_HZ);
  localparam logic [31:0] L_WIN   = ns_to_cycles(P_ESC_WINDOW_NS, P_CLK_FREQ_HZ);
  localparam logic [31:0] L_ESC   = 32'(P_ESC_KICKS);
  localparam logic [4:0]  L_LAST  = 5'(P_N_STAGES - 1);

  seq_state_e            r_state;
  logic [31:0]           r_cnt;
  logic [4:0]            r_stage;
  logic [P_N_STAGES-1:0] r_rst_out_n;
  logic                  r_busy;
  logic                  r_escalated;
  logic                  r_kick_d;
  logic [7:0]            r_esc_cnt;
  logic [15:0]           r_kick_cnt;

  seq_state_e            w_state_nxt;
  logic [31:0]           w_cnt_nxt;
  logic [4:0]            w_stage_nxt;
  logic [P_N_STAGES-1:0] w_rst_nxt;
  logic                  w_tmr_clr;
  logic                  w_wrap;
  logic                  w_kick_ev;

  assign w_kick_ev = kick & ~r_kick_d;

  wdog_win_timer #(
    .P_WIN_CYC (L_WIN)
  ) u_win_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tmr_clr),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_rst_nxt   = r_rst_out_n;
    w_tmr_clr   = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        w_rst_nxt = '0;
        // A kick still high keeps restarting the hold; it only counts from the fall.
        if (kick) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == L_HOLD) begin
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
          w_state_nxt = ({24'd0, r_esc_cnt} >= L_ESC) ? ST_LOCKED : ST_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_RELEASE: begin
        if (w_kick_ev) begin
          w_rst_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ASSERT;
        end else if (r_cnt == L_STAGE) begin
          w_rst_nxt   = r_rst_out_n | (P_N_STAGES'(1) << r_stage);
          w_cnt_nxt   = '0;
          w_stage_nxt = r_stage + 5'd1;
          if (r_stage == L_LAST) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_IDLE: begin
        w_rst_nxt = '1;
        if (w_kick_ev) begin
          w_rst_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_LOCKED: begin
        w_rst_nxt = '0;
        if (clr_esc) begin
          w_tmr_clr   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ASSERT;
        end
      end
      default: begin
        w_state_nxt = ST_ASSERT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ASSERT;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_rst_out_n <= '0;
      r_busy      <= 1'b1;
      r_escalated <= 1'b0;
      r_kick_d    <= 1'b1;
      r_esc_cnt   <= '0;
      r_kick_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stage     <= w_stage_nxt;
      r_rst_out_n <= w_rst_nxt;
      r_busy      <= ~&w_rst_nxt;
      r_escalated <= (w_state_nxt == ST_LOCKED);
      r_kick_d    <= kick;
      // A kick landing on the wrap cycle opens the new window with a count of one.
      if (w_tmr_clr) begin
        r_esc_cnt <= '0;
      end else if (w_wrap) begin
        r_esc_cnt <= w_kick_ev ? 8'd1 : 8'd0;
      end else if (w_kick_ev && (r_esc_cnt != 8'hFF)) begin
        r_esc_cnt <= r_esc_cnt + 8'd1;
      end
      if (w_kick_ev && (r_kick_cnt != 16'hFFFF)) begin
        r_kick_cnt <= r_kick_cnt + 16'd1;
      end
    end
  end

  assign rst_out_n = r_rst_out_n;
  assign busy      = r_busy;
  assign escalated = r_escalated;
  assign kick_cnt  = r_kick_cnt;

endmodule

// File: doc/wdog_rst_seq.md
# wdog_rst_seq

Reset sequencer that sits directly downstream of the watchdog and consumes its `kick` output. Each kick asserts a bank of active-low reset outputs, holds them for a minimum time, then releases them one stage at a time in a fixed order. Repeated kicks inside a time window escalate to a locked state that holds every stage in reset until software clears it. It also keeps a saturating count of kick events for status readout.

## Interface
- `P_CLK_FREQ_HZ`, 64-bit, default 100000000: clock frequency.
- `P_HOLD_NS`, 64-bit, default 1000: minimum reset assertion after `kick` falls.
- `P_STAGE_NS`, 64-bit, default 500: spacing between successive stage releases.
- `P_N_STAGES`, default 4: number of reset outputs, range 1..16.
- `P_ESC_KICKS`, default 3: number of kicks within one window that causes lock.
- `P_ESC_WINDOW_NS`, 64-bit, default 2000000000: escalation window length.
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `kick`, input, 1: watchdog kick level, high = demand reset.
- `clr_esc`, input, 1: single-cycle pulse that leaves LOCKED.
- `rst_out_n`, output, P_N_STAGES: stage resets, active-low; bit 0 is released first.
- `busy`, output, 1: high whenever any bit of `rst_out_n` is 0.
- `escalated`, output, 1: high while in LOCKED.
- `kick_cnt`, output, 16: total kick rising edges, saturating.

## Operation
- Cycle constants are computed as `NS*P_CLK_FREQ_HZ/1000000000`, evaluated in 64 bits and truncated to 32: L_HOLD, L_STAGE, L_WIN. Each state counter is 32-bit.
- Kick event detection: `kick & ~kick_d`. `kick_d` resets to 1, so a kick held high out of reset is not counted as an event.
- State ASSERT:
  - All `rst_out_n`=0.
  - While `kick`=1, `cnt` is held at 0.
  - While `kick`=0, `cnt` increments.
  - When `cnt`==L_HOLD: go to LOCKED if `esc_cnt`>=P_ESC_KICKS; otherwise go to RELEASE with `stage`=0 and `cnt`=0.
- State RELEASE:
  - When `cnt`==L_STAGE, set `rst_out_n[stage]`=1, increment `stage`, and clear `cnt`.
  - After bit P_N_STAGES-1 is released, go to IDLE.
  - A kick event in RELEASE forces all bits to 0 and goes to ASSERT with `cnt`=0 on the next cycle.
- State IDLE: all bits are 1. A kick event goes to ASSERT.
- State LOCKED:
  - All bits are 0 and `escalated`=1.
  - `kick` is ignored for state purposes but still counted.
  - `clr_esc` clears `esc_cnt` and the window counter, then goes to ASSERT.
- Escalation window:
  - The window counter runs continuously. At L_WIN it wraps to 0 and clears `esc_cnt`.
  - Each kick event increments `esc_cnt`, saturating at 255.
  - If wrap and a kick event occur in the same cycle, `esc_cnt` becomes 1.
- `kick_cnt` increments on every kick event and saturates at 0xFFFF. Only `rst_n` clears it.
- `clr_esc` outside LOCKED has no effect.

## Timing
- Reset values:
  - state=ASSERT, so power-up performs a full hold-then-release sequence.
  - `rst_out_n`=0, `busy`=1, `escalated`=0, `kick_cnt`=0, `esc_cnt`=0.
- All outputs are registered.
- A kick event at cycle t (the first cycle `kick`=1 is sampled) drives all `rst_out_n` low at t+1.
- Hold time: with `kick` falling at cycle f (first sample of 0), ASSERT exits at f+L_HOLD.
  - Bit 0 rises at f+L_HOLD+L_STAGE+2.
  - Each further bit rises L_STAGE+1 cycles after the previous one.
- `busy` falls in the same cycle the last bit rises.
- A mid-sequence `rst_n` assertion immediately forces the reset values, asynchronously.
- P_N_STAGES=1 gives a single release, then IDLE.

## Structure
- Shared package/include `wdog_pkg` holds:
  - state encodings (IDLE, ASSERT, RELEASE, LOCKED);
  - the ns-to-cycles constant function, also used by the watchdog.
- One sub-module, `wdog_win_timer`:
  - free-running window counter with `wrap` pulse output;
  - synchronous clear input driven by `clr_esc`.
- Target size is 150–250 lines of RTL.

## Test plan
Common parameters: 100 MHz clock, P_HOLD_NS=100 (L_HOLD=10), P_STAGE_NS=50 (L_STAGE=5), P_N_STAGES=4, P_ESC_KICKS=3, P_ESC_WINDOW_NS=10000 (L_WIN=1000).

1. Power-up with `kick`=1 for 20 cycles after `rst_n` rises.
   - Expect `kick_cnt`=0.
   - After `kick` falls, bits 0..3 rise 6 cycles apart, bit 0 at fall+17.
   - `busy` falls with bit 3.
2. Single kick pulse of 1 cycle from IDLE.
   - Expect `rst_out_n`=4'b0000 next cycle.
   - Expect `kick_cnt`=1 and the release order 0001, 0011, 0111, 1111.
3. Kick arriving while `rst_out_n`=4'b0011 in RELEASE.
   - Expect 4'b0000 next cycle and a fresh hold plus full release.
4. Three kicks within 1000 cycles.
   - Expect LOCKED after the third hold: `escalated`=1, `rst_out_n`=0 indefinitely.
   - Pulse `clr_esc`: expect a full sequence, `escalated`=0, `kick_cnt`=3.
5. Two kicks, then wait past window wrap, then one kick.
   - Expect no lock (`esc_cnt`=1).
   - Also cover a kick in the exact wrap cycle: expect `esc_cnt`=1.
6. Force `kick_cnt` to 0xFFFE, then issue 3 events.
   - Expect saturation at 0xFFFF.
   - Assert `rst_n` mid-RELEASE: expect all outputs at reset values immediately.
